jingle_player: RTL

Next-generation jingle playback engine for the synthesizer audio path. It streams one of JINGLE_CNT sample sequences from an external synchronous ROM into the DAC FIFO. Compared with the previous sender, it adds:
- a parametrised ROM latency, with credit-based prefetch and a small skid FIFO;
- a valid/ready output handshake;
- one-shot and loop modes;
- start/stop control;
- per-jingle attenuation;
- a done pulse.

It sits between the control/keyboard logic and the DAC FIFO writer.

---
 rtl/jingle_player.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/jingle_player.sv
// jingle_player: streams a ROM jingle into the DAC FIFO.
// The design uses credit-based prefetch, a skid FIFO, loop/one-shot modes,
// start/stop control, attenuation and a done pulse.
// Defining JINGLE_PLAYER_POS_EN adds the pos_o and loop_cnt_o outputs.
module jingle_player #(
  parameter int JINGLE_CNT   = 8,
  parameter int SAMPLE_WIDTH = 16,
  parameter int SAMPLES_CNT  = 512,
  parameter int ROM_LATENCY  = 2,
  parameter int ATT_WIDTH    = 4,
  localparam int JW = $clog2(JINGLE_CNT),
  localparam int IW = $clog2(SAMPLES_CNT),
  localparam int AW = $clog2(JINGLE_CNT*SAMPLES_CNT)
)(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic [JW-1:0]           jingle_num_i,
  input  logic                    loop_i,
  input  logic [ATT_WIDTH-1:0]    att_i,
  output logic [AW-1:0]           rom_addr_o,
  output logic                    rom_rd_o,
  input  logic [SAMPLE_WIDTH:0]   rom_data_i,
  output logic [SAMPLE_WIDTH-1:0] samp_data_o,
  output logic                    samp_valid_o,
  input  logic                    samp_ready_i,
  output logic                    busy_o,
  output logic                    done_o
`ifdef JINGLE_PLAYER_POS_EN
  ,
  output logic [IW-1:0]           pos_o,
  output logic [15:0]             loop_cnt_o
`endif
);
  localparam int D  = ROM_LATENCY + 1;
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(2*ROM_LATENCY + 3);

  typedef enum logic [1:0] {IDLE, PLAY, FLUSH} state_t;

  state_t                  r_state, w_state_nx;
  logic [JW-1:0]           r_jingle;
  logic                    r_loop;
  logic [ATT_WIDTH-1:0]    r_att;
  logic [IW-1:0]           r_index;
  logic                    r_end;
  logic [ROM_LATENCY-1:0]  r_pipe, r_plast;
  logic [SAMPLE_WIDTH-1:0] r_mem [D];
  logic [PW-1:0]           r_wr, r_rd;
  logic [CW-1:0]           r_cnt, w_infl;
  logic                    w_ret, w_push, w_wrap, w_pop, w_ctl, w_credit;
  logic [IW-1:0]           w_idx;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(D-1)) ? '0 : p + PW'(1);
  endfunction

  // Count reads still in flight, including the one returning this cycle.
  always_comb begin
    w_infl = '0;
    for (int k = 0; k < ROM_LATENCY; k++) w_infl = w_infl + CW'(r_pipe[k]);
  end

  // r_pipe tags the live reads; its top bit marks the word on rom_data_i now.
  // r_plast marks a read of the final index, which ends the pass without a marker.
  assign w_ret    = r_pipe[ROM_LATENCY-1];
  assign w_push   = w_ret && !rom_data_i[SAMPLE_WIDTH];
  assign w_wrap   = w_ret && (rom_data_i[SAMPLE_WIDTH] || r_plast[ROM_LATENCY-1]);
  assign w_pop    = samp_valid_o && samp_ready_i;
  assign w_ctl    = start_i || stop_i;
  // A slot freed by this cycle's transfer can be reused at once.
  // This keeps one sample per cycle under steady ready.
  assign w_credit = (r_cnt + w_infl) < (CW'(D) + CW'(w_pop));
  // On a wrap, word 0 is fetched in the same cycle to keep the loop bubble short.
  assign w_idx    = w_wrap ? '0 : r_index;

  assign rom_addr_o   = {r_jingle, w_idx};
  assign samp_valid_o = r_cnt != '0;
  assign samp_data_o  = $signed(r_mem[r_rd]) >>> r_att;
  assign busy_o       = r_state != IDLE;

  // Next state, read issue and done pulse; stop beats start, and both beat everything else.
  always_comb begin
    w_state_nx = r_state;
    rom_rd_o   = 1'b0;
    done_o     = 1'b0;
    if (stop_i) w_state_nx = IDLE;
    else if (start_i) w_state_nx = PLAY;
    else if (r_state == PLAY) begin
      rom_rd_o = (w_wrap ? r_loop : !r_end) && w_credit;
      if (w_wrap && !r_loop) w_state_nx = FLUSH;
    end else if (r_state == FLUSH && r_cnt == '0) begin
      done_o     = 1'b1;
      w_state_nx = IDLE;
    end
  end

  // State, latched parameters, read index and in-flight read tags.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_state  <= IDLE;
      r_jingle <= '0;
      r_loop   <= 1'b0;
      r_att    <= '0;
      r_index  <= '0;
      r_end    <= 1'b0;
      r_pipe   <= '0;
      r_plast  <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_ctl) begin
        r_index <= '0;
        r_end   <= 1'b0;
        r_pipe  <= '0;
        r_plast <= '0;
        if (!stop_i) begin
          r_jingle <= jingle_num_i;
          r_loop   <= loop_i;
          r_att    <= att_i;
        end
      end else begin
        r_pipe  <= w_wrap ? ROM_LATENCY'(rom_rd_o) : ROM_LATENCY'({r_pipe, rom_rd_o});
        r_plast <= w_wrap ? '0 : ROM_LATENCY'({r_plast, rom_rd_o && &r_index});
        if (rom_rd_o) begin
          r_index <= w_idx + IW'(1);
          r_end   <= !w_wrap && &r_index;
        end else if (w_wrap) begin
          r_index <= '0;
          r_end   <= 1'b0;
        end
      end
    end

  // Skid FIFO; start or stop empties it, and marker words are never written into it.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int k = 0; k < D; k++) r_mem[k] <= '0;
    end else if (w_ctl) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= rom_data_i[SAMPLE_WIDTH-1:0];
        r_wr        <= nxt(r_wr);
      end
      if (w_pop) r_rd <= nxt(r_rd);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end

`ifdef JINGLE_PLAYER_POS_EN
  logic [IW-1:0] r_pidx [ROM_LATENCY];
  logic [IW-1:0] r_fidx [D];
  logic [IW-1:0] r_pos;
  logic [15:0]   r_loop_cnt;

  assign pos_o      = r_pos;
  assign loop_cnt_o = r_loop_cnt;

  // Carry each word's index through the ROM pipe and FIFO, and count loop passes.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      for (int k = 0; k < ROM_LATENCY; k++) r_pidx[k] <= '0;
      for (int k = 0; k < D; k++) r_fidx[k] <= '0;
      r_pos      <= '0;
      r_loop_cnt <= '0;
    end else begin
      r_pidx[0] <= w_idx;
      for (int k = 1; k < ROM_LATENCY; k++) r_pidx[k] <= r_pidx[k-1];
      if (w_push) r_fidx[r_wr] <= r_pidx[ROM_LATENCY-1];
      if (start_i && !stop_i) begin
        r_pos      <= '0;
        r_loop_cnt <= '0;
      end else if (!stop_i) begin
        if (w_pop) r_pos <= r_fidx[r_rd];
        if (r_state == PLAY && w_wrap && r_loop && r_loop_cnt != 16'hFFFF)
          r_loop_cnt <= r_loop_cnt + 16'd1;
      end
    end
`endif
endmodule
